// File: rtl/rpi_irq_pkg.sv
// rpi_irq_pkg: shared FSM state type and width helpers for the RPi interrupt clock generator.
// RPI_IRQ_CLK_ID_ENCODE_EN widens the pulse counter so the source index can be added to the burst length.
package rpi_irq_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int bw, input int sw);
`ifdef RPI_IRQ_CLK_ID_ENCODE_EN
    return bw + sw;
`else
    return bw + 0 * sw;
`endif
  endfunction
endpackage

// File: rtl/rpi_irq_arbiter.sv
// rpi_irq_arbiter: fixed-priority (lowest index wins) one-hot grant and encoded index.
module rpi_irq_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  assign gnt = req & (~req + N'(1));
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
  end
endmodule

// File: rtl/rpi_irq_clk_gen.sv
// rpi_irq_clk_gen: latches request edges, grants lowest pending source, emits a finite clk_out burst.
// Define RPI_IRQ_CLK_ID_ENCODE_EN to add the served source index to the pulse count.
module rpi_irq_clk_gen import rpi_irq_pkg::*; #(
  parameter int NUM_SRC = 4,
  parameter int DIV_W = 6,
  parameter int BURST_W = 4,
  parameter int GAP_CYC = 4,
  localparam int SRC_W = src_w(NUM_SRC),
  localparam int CNT_W = cnt_w(BURST_W, SRC_W)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               enable,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic [DIV_W-1:0]   div_half,
  input  logic [BURST_W-1:0] burst_len,
  output logic               clk_out,
  output logic               busy,
  output logic [SRC_W-1:0]   irq_id,
  output logic [NUM_SRC-1:0] irq_ack,
  output logic [NUM_SRC-1:0] pending
);
  localparam logic [DIV_W-1:0] GAP_L = DIV_W'(GAP_CYC);
  state_t state_q, state_d;
  logic clk_q, clk_d, busy_q, busy_d, grant, ph_done;
  logic [SRC_W-1:0] id_q, id_d, gnt_id;
  logic [NUM_SRC-1:0] ack_q, ack_d, pend_q, pend_d, req_q, gnt;
  logic [DIV_W-1:0] div_q, div_d, ph_q, ph_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, target;
  rpi_irq_arbiter #(.N(NUM_SRC), .W(SRC_W)) u_arb (.req(pend_q), .gnt(gnt), .idx(gnt_id));
`ifdef RPI_IRQ_CLK_ID_ENCODE_EN
  assign target = CNT_W'(len_q) + CNT_W'(id_q);
`else
  assign target = CNT_W'(len_q);
`endif
  assign grant = (state_q == IDLE) && enable && (|pend_q);
  assign ph_done = ph_q >= div_q;
  always_comb begin
    state_d = state_q;
    clk_d = clk_q;
    busy_d = busy_q;
    id_d = id_q;
    div_d = div_q;
    len_d = len_q;
    cnt_d = cnt_q;
    ack_d = '0;
    ph_d = (state_q == IDLE) ? ph_q : ph_q + DIV_W'(1);
    // a fresh edge is ORed in after the grant clear so a coincident re-request survives
    pend_d = (pend_q & ~(grant ? gnt : '0)) | (irq_req & ~req_q);
    case (state_q)
      IDLE: if (grant) begin
        state_d = HIGH;
        clk_d = 1'b1;
        busy_d = 1'b1;
        id_d = gnt_id;
        div_d = (div_half == '0) ? DIV_W'(1) : div_half;
        len_d = (burst_len == '0) ? BURST_W'(1) : burst_len;
        cnt_d = CNT_W'(1);
        ph_d = DIV_W'(1);
      end
      HIGH: if (ph_done) begin
        state_d = LOW;
        clk_d = 1'b0;
        ph_d = DIV_W'(1);
      end
      LOW: if (ph_done) begin
        ph_d = DIV_W'(1);
        state_d = (cnt_q < target) ? HIGH : GAP;
        clk_d = cnt_q < target;
        cnt_d = (cnt_q < target) ? cnt_q + CNT_W'(1) : cnt_q;
        ack_d = (cnt_q < target) ? '0 : NUM_SRC'(1) << id_q;
      end
      GAP: if (ph_q >= GAP_L) begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      clk_q <= 1'b0;
      busy_q <= 1'b0;
      id_q <= '0;
      ack_q <= '0;
      pend_q <= '0;
      req_q <= '0;
      div_q <= DIV_W'(1);
      len_q <= BURST_W'(1);
      cnt_q <= '0;
      ph_q <= '0;
    end else begin
      state_q <= state_d;
      clk_q <= clk_d;
      busy_q <= busy_d;
      id_q <= id_d;
      ack_q <= ack_d;
      pend_q <= pend_d;
      req_q <= irq_req;
      div_q <= div_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      ph_q <= ph_d;
    end
  end
  assign clk_out = clk_q;
  assign busy = busy_q;
  assign irq_id = id_q;
  assign irq_ack = ack_q;
  assign pending = pend_q;
endmodule

// File: tb/tb_rpi_irq_clk_gen.sv
// tb_rpi_irq_clk_gen: directed self-checking bench; expected pulse counts follow RPI_IRQ_CLK_ID_ENCODE_EN.
module tb_rpi_irq_clk_gen;
`ifdef RPI_IRQ_CLK_ID_ENCODE_EN
  localparam int ENC = 1;
`else
  localparam int ENC = 0;
`endif
  logic clk_in = 0, rst_in = 1, enable = 1;
  logic [3:0] irq_req = '0;
  logic [5:0] div_half = 6'd3;
  logic [3:0] burst_len = 4'd2;
  logic clk_out, busy;
  logic [1:0] irq_id;
  logic [3:0] irq_ack, pending;
  int total = 0, bad = 0;
  always #10 clk_in = ~clk_in;
  rpi_irq_clk_gen dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable(enable), .irq_req(irq_req),
    .div_half(div_half), .burst_len(burst_len), .clk_out(clk_out), .busy(busy),
    .irq_id(irq_id), .irq_ack(irq_ack), .pending(pending)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic trig(input logic [3:0] m);
    @(negedge clk_in);
    irq_req = '0;
    @(negedge clk_in);
    irq_req = m;
  endtask
  task automatic burst_chk(input string tag, input int max_cyc, input int e_np, input int e_h,
                           input int e_l, input int e_ack, input int e_id, input int e_pend, input int e_first);
    int np, hmin, hmax, lmin, lmax, ackn, gap, gclk, first, run, id0, pend0, ackv;
    bit p, gap_on, tmo;
    np = 0; hmin = 9999; hmax = 0; lmin = 9999; lmax = 0; ackn = 0; gap = 0; gclk = 0;
    first = -1; run = 0; id0 = -1; pend0 = -1; ackv = 0; p = 0; gap_on = 0; tmo = 1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_in);
      if (irq_ack != 0) begin ackv = irq_ack; ackn++; end
      if (!gap_on && irq_ack != 0) begin
        gap_on = 1;
        if (np > 0) begin lmin = (run < lmin) ? run : lmin; lmax = (run > lmax) ? run : lmax; end
      end
      if (gap_on) begin
        if (!busy) begin tmo = 0; break; end
        gap++;
        if (clk_out) gclk++;
      end else if (clk_out && !p) begin
        np++;
        if (np == 1) begin first = i; id0 = irq_id; pend0 = pending; end
        else begin lmin = (run < lmin) ? run : lmin; lmax = (run > lmax) ? run : lmax; end
        run = 1;
      end else if (!clk_out && p) begin
        hmin = (run < hmin) ? run : hmin; hmax = (run > hmax) ? run : hmax;
        run = 1;
      end else run++;
      p = clk_out;
    end
    chk({tag, "_tmo"}, tmo, 0);
    chk({tag, "_pulses"}, np, e_np);
    chk({tag, "_hmin"}, hmin, e_h);
    chk({tag, "_hmax"}, hmax, e_h);
    chk({tag, "_lmin"}, lmin, e_l);
    chk({tag, "_lmax"}, lmax, e_l);
    chk({tag, "_ack"}, ackv, e_ack);
    chk({tag, "_ackn"}, ackn, 1);
    chk({tag, "_gap"}, gap, 4);
    chk({tag, "_gapclk"}, gclk, 0);
    chk({tag, "_id"}, id0, e_id);
    chk({tag, "_pend"}, pend0, e_pend);
    chk({tag, "_first"}, first, e_first);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int ackseen, busyseen;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_clk", clk_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_id", irq_id, 0);
    chk("rst_ack", irq_ack, 0);
    chk("rst_pend", pending, 0);
    rst_in = 0;
    // single burst; parameter changes after the grant must not affect it
    trig(4'b0001);
    fork
      burst_chk("single", 400, 2, 3, 3, 1, 0, 0, 1);
      begin repeat (4) @(negedge clk_in); div_half = 6'd7; burst_len = 4'd9; end
    join
    // priority between two simultaneous edges
    div_half = 6'd1; burst_len = 4'd1;
    trig(4'b0110);
    burst_chk("prio1", 400, 1 + ENC, 1, 1, 2, 1, 4, 1);
    burst_chk("prio2", 400, 1 + 2 * ENC, 1, 1, 4, 2, 0, 0);
    // zero values act as one
    div_half = 6'd0; burst_len = 4'd0;
    trig(4'b1000);
    burst_chk("min", 400, 1 + 3 * ENC, 1, 1, 8, 3, 0, 1);
    div_half = 6'd63; burst_len = 4'd15;
    trig(4'b0010);
    burst_chk("max", 4000, 15 + ENC, 63, 63, 2, 1, 0, 1);
    // identity encoding visible in pulse count
    div_half = 6'd1; burst_len = 4'd2;
    trig(4'b1000);
    burst_chk("enc3", 400, 2 + 3 * ENC, 1, 1, 8, 3, 0, 1);
    trig(4'b0001);
    burst_chk("enc0", 400, 2, 1, 1, 1, 0, 0, 1);
    // enable low blocks grants
    enable = 0;
    trig(4'b0001);
    repeat (8) @(negedge clk_in);
    chk("dis_busy", busy, 0);
    chk("dis_clk", clk_out, 0);
    chk("dis_pend", pending, 4'b0001);
    enable = 1;
    burst_chk("en", 400, 2, 1, 1, 1, 0, 0, 0);
    // enable drop mid-burst: burst finishes, new request waits
    div_half = 6'd2;
    trig(4'b0100);
    fork
      burst_chk("drop", 400, 2 + 2 * ENC, 2, 2, 4, 2, 0, 1);
      begin repeat (3) @(negedge clk_in); enable = 0; irq_req[1] = 1; end
    join
    repeat (8) @(negedge clk_in);
    chk("drop_busy", busy, 0);
    chk("drop_pend", pending, 4'b0010);
    enable = 1;
    burst_chk("drop2", 400, 2 + ENC, 2, 2, 2, 1, 0, 0);
    // re-edge on the served source re-pends it
    trig(4'b0001);
    fork
      burst_chk("re1", 400, 2, 2, 2, 1, 0, 0, 1);
      begin
        repeat (2) @(negedge clk_in); irq_req[0] = 0;
        @(negedge clk_in); irq_req[0] = 1;
        repeat (2) @(negedge clk_in);
        chk("re_pend", pending, 4'b0001);
      end
    join
    burst_chk("re2", 400, 2, 2, 2, 1, 0, 0, 0);
    // asynchronous reset mid-burst
    div_half = 6'd3;
    trig(4'b0001);
    repeat (3) @(negedge clk_in);
    irq_req[1] = 1;
    @(negedge clk_in);
    chk("mid_clk", clk_out, 1);
    chk("mid_pend", pending, 4'b0010);
    irq_req = '0;
    #2 rst_in = 1;
    #1;
    chk("arst_clk", clk_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pend", pending, 0);
    chk("arst_ack", irq_ack, 0);
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 0;
    ackseen = 0; busyseen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (irq_ack != 0) ackseen++;
      if (busy) busyseen++;
    end
    chk("post_ack", ackseen, 0);
    chk("post_busy", busyseen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
